pwm_drive: RTL and testbench
============================

# pwm_drive

Duty-cycle output stage that consumes the 3-bit `dc_control` word produced by the duty-cycle store and turns it into a PWM waveform. It also generates the 3-bit `trigger` phase count that the store samples: `trigger == 0` marks the start of each PWM period. A new duty value is taken only at period boundaries, with an optional one-step-per-period slew limit for soft start and soft stop.

## Interface
- `PRESCALE`, default 4: clock cycles per phase step; legal range 1..255.
- `SLEW`, default 1: 1 = applied duty moves at most ±1 per period; 0 = applied duty jumps directly to the request.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (asserted when 0).
- `en`  in  1  run enable; sampled on `clk`.
- `dc_control`  in  3  requested duty, 0..7 eighths; sampled only at period boundaries.
- `trigger`  out  3  phase counter 0..7; 0 = first phase of a period.
- `pwm`  out  1  registered PWM output.
- `duty_applied`  out  3  duty currently in effect.
- `period_start`  out  1  one-cycle pulse on each period boundary.

## Operation
- Internal prescaler `pcnt`, width ceil(log2(PRESCALE)), minimum 1 bit.
  - `pcnt` counts 0..PRESCALE-1.
  - A tick is the cycle in which `pcnt == PRESCALE-1`. For PRESCALE=1, every cycle is a tick.
- On a tick, `trigger` increments modulo 8.
- Boundary: a tick while `trigger == 7`. At the boundary edge:
  - `trigger` goes to 0.
  - `period_start` goes to 1 for exactly one cycle.
  - `duty_applied` updates from `dc_control`.
- Duty update rule:
  - SLEW=0: `duty_applied` <= `dc_control`.
  - SLEW=1: if `dc_control` > `duty_applied`, then +1; if smaller, then -1; if equal, hold.
  - 3-bit unsigned arithmetic. The step direction guarantees no wrap.
- Changes on `dc_control` between boundaries are ignored.
- `pwm` is registered. After every edge it equals `en_s && (trigger < duty_applied)`, evaluated on the values `trigger` and `duty_applied` take at that same edge (`en_s` is `en` as sampled at that edge).
  - Duty 0: `pwm` is never high.
  - Duty 7: high for 7 of 8 phases.
  - No 8/8 duty exists.
- `en` low (synchronous): `pcnt`, `trigger`, `duty_applied`, `pwm` and `period_start` all go to 0 on the next edge and hold there.
- `en` rising: counting resumes from `trigger = 0`, `pcnt = 0`.
  - No `period_start` is issued for this first period.
  - The first period runs at duty 0.
  - The first update happens at the first boundary. This gives a soft start from 0 when SLEW=1.

## Timing
- `rst` low: all outputs and internal state go to 0 immediately. Outputs stay 0 while `rst` is low.
- After `rst` releases, the behaviour is identical to an `en` rising edge.
- Period = 8*PRESCALE cycles.
- `period_start` fires exactly once per period while `en` is held high.
- `trigger` holds each value for PRESCALE cycles.
- Latency from `dc_control` to `pwm`:
  - `dc_control` is sampled at the next boundary edge.
  - The new duty is visible on `pwm` in the same cycle that `trigger` becomes 0.
- SLEW=1: a full 0→7 ramp takes 7 periods.
- Boundary and `en` falling on the same edge: `en` wins, and all state goes to 0.
- `rst` asserted mid-period: everything goes to 0 asynchronously. There is no partial-period output afterwards.

## Test plan
- PRESCALE=4, SLEW=0, `en`=1, `dc_control`=3 → after the first boundary, each 32-cycle period has `pwm` high 12 cycles then low 20; `period_start` high one cycle out of 32, aligned with `trigger`=0.
- SLEW=1, `dc_control` 0→7, held → `duty_applied` reads 1,2,…,7 at successive boundaries; then `dc_control`=2 → reads 6,5,4,3,2, then holds at 2.
- `dc_control` toggles 5→1→5 inside one period (SLEW=0, applied value 5) → `duty_applied` and `pwm` pattern unchanged until the boundary; the boundary loads 5.
- `dc_control`=0 → `pwm` never high; `dc_control`=7 (SLEW=0) → `pwm` low exactly PRESCALE cycles per period, during `trigger`=7.
- `en` dropped while `pwm`=1 at `trigger`=2 → next edge: `pwm`=0, `trigger`=0, `duty_applied`=0; `en` reasserted → first period all low, then the ramp restarts from 1 (SLEW=1).
- `rst` pulsed low mid-period between clock edges → outputs go to 0 without a clock; after release, the same sequence as the `en` scenario. With PRESCALE=1, `trigger` advances every cycle.

Source files
------------

// File: rtl/pwm_drive_if.sv
// Duty-control handshake between the duty-cycle store and the PWM output stage.
// The store drives en/dc_control and samples trigger; the output stage drives the waveform side.
interface pwm_drive_if;
  logic       en;
  logic [2:0] dc_control;
  logic [2:0] trigger;
  logic       pwm;
  logic [2:0] duty_applied;
  logic       period_start;

  modport master (
    output en, dc_control,
    input  trigger, pwm, duty_applied, period_start
  );

  modport slave (
    input  en, dc_control,
    output trigger, pwm, duty_applied, period_start
  );
endinterface

// File: rtl/pwm_drive.sv
// PWM output stage: 8-phase period of PRESCALE cycles per phase, duty loaded (optionally slewed) at boundaries.
// New duty shows on pwm the cycle trigger returns to 0; no backpressure, en low clears everything next edge.
module pwm_drive #(
  parameter int PRESCALE = 4,
  parameter bit SLEW     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  pwm_drive_if.slave  bus
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt, pcnt_nx;
  logic [2:0]    trig, trig_nx;
  logic [2:0]    duty, duty_nx;
  logic          pwm_q, pwm_nx;
  logic          ps_q, ps_nx;
  logic          tick, bnd;

  always_comb begin
    pcnt_nx = '0;
    trig_nx = '0;
    duty_nx = '0;
    ps_nx   = 1'b0;
    pwm_nx  = 1'b0;
    tick    = (pcnt == PMAX);
    bnd     = tick && (trig == 3'd7);
    if (bus.en) begin
      pcnt_nx = tick ? '0 : pcnt + PW'(1);
      trig_nx = tick ? trig + 3'd1 : trig;
      duty_nx = duty;
      if (bnd) begin
        // Slewed steps move toward the request, so 3-bit arithmetic never wraps.
        if (SLEW == 1'b0)
          duty_nx = bus.dc_control;
        else if (bus.dc_control > duty)
          duty_nx = duty + 3'd1;
        else if (bus.dc_control < duty)
          duty_nx = duty - 3'd1;
      end
      ps_nx  = bnd;
      // Compare against next-state values so pwm lines up with the trigger it is registered with.
      pwm_nx = (trig_nx < duty_nx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt  <= '0;
      trig  <= '0;
      duty  <= '0;
      pwm_q <= 1'b0;
      ps_q  <= 1'b0;
    end else begin
      pcnt  <= pcnt_nx;
      trig  <= trig_nx;
      duty  <= duty_nx;
      pwm_q <= pwm_nx;
      ps_q  <= ps_nx;
    end
  end

  assign bus.trigger      = trig;
  assign bus.pwm          = pwm_q;
  assign bus.duty_applied = duty;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_drive.sv
// Bench for pwm_drive: three instances (P4/no-slew, P4/slew, P1/slew) share stimulus and are
// compared every cycle against a cycle-count reference model, plus directed ramp/duty checks.
module tb_pwm_drive;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] dc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_drive_if if0 ();
  pwm_drive_if if1 ();
  pwm_drive_if if2 ();

  assign if0.en = en;  assign if0.dc_control = dc;
  assign if1.en = en;  assign if1.dc_control = dc;
  assign if2.en = en;  assign if2.dc_control = dc;

  pwm_drive #(.PRESCALE(4), .SLEW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  pwm_drive #(.PRESCALE(4), .SLEW(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  pwm_drive #(.PRESCALE(1), .SLEW(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0] o_trig [3];
  logic [2:0] o_duty [3];
  logic       o_pwm  [3];
  logic       o_ps   [3];

  assign o_trig[0] = if0.trigger;  assign o_duty[0] = if0.duty_applied;
  assign o_pwm[0]  = if0.pwm;      assign o_ps[0]   = if0.period_start;
  assign o_trig[1] = if1.trigger;  assign o_duty[1] = if1.duty_applied;
  assign o_pwm[1]  = if1.pwm;      assign o_ps[1]   = if1.period_start;
  assign o_trig[2] = if2.trigger;  assign o_duty[2] = if2.duty_applied;
  assign o_pwm[2]  = if2.pwm;      assign o_ps[2]   = if2.period_start;

  // Reference model: edges counted since the last clear, plus the duty in effect.
  int mp [3] = '{4, 4, 1};
  int ms [3] = '{0, 1, 1};
  int mn [3];
  int md [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mn[i] = 0;
      md[i] = 0;
    end
  endtask

  task automatic model_edge(input logic e, input logic [2:0] d);
    for (int i = 0; i < 3; i++) begin
      if (!rst || !e) begin
        mn[i] = 0;
        md[i] = 0;
      end else begin
        mn[i]++;
        if (mn[i] % (8 * mp[i]) == 0) begin
          if (ms[i] == 0)         md[i] = int'(d);
          else if (int'(d) > md[i]) md[i] = md[i] + 1;
          else if (int'(d) < md[i]) md[i] = md[i] - 1;
        end
      end
    end
  endtask

  task automatic check_all();
    int et;
    for (int i = 0; i < 3; i++) begin
      et = (mn[i] / mp[i]) % 8;
      chk($sformatf("trigger[%0d]", i), 32'(o_trig[i]), 32'(et));
      chk($sformatf("duty[%0d]", i),    32'(o_duty[i]), 32'(md[i]));
      chk($sformatf("pwm[%0d]", i),     32'(o_pwm[i]),  32'(et < md[i]));
      chk($sformatf("pstart[%0d]", i),  32'(o_ps[i]),
          32'(mn[i] > 0 && (mn[i] % (8 * mp[i]) == 0)));
    end
  endtask

  // Called just after a rising edge; inputs change here, away from the next edge.
  task automatic cyc(input logic e, input logic [2:0] d);
    en = e;
    dc = d;
    @(posedge clk);
    model_edge(e, d);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #3;
    rst = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk);
    model_edge(en, dc);
    #1;
    check_all();
    #2;
    rst = 1'b1;
    @(posedge clk);
    model_edge(en, dc);
    #1;
    check_all();
  endtask

  int         hi_cnt, ps_cnt, guard;
  logic [2:0] ramp_q[$];
  logic [2:0] ramp_up [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
  logic [2:0] ramp_dn [6] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd2};
  logic [2:0] rd;
  logic       re;

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    dc  = 3'd0;
    model_clear();
    #13;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Duty 3/8 at PRESCALE=4: 12 high cycles and one period_start per 32-cycle period.
    for (int i = 0; i < 32; i++) cyc(1'b1, 3'd3);
    hi_cnt = 0;
    ps_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      cyc(1'b1, 3'd3);
      hi_cnt += int'(if0.pwm);
      ps_cnt += int'(if0.period_start);
    end
    chk("duty3_high_cycles", 32'(hi_cnt), 32'd72);
    chk("duty3_period_starts", 32'(ps_cnt), 32'd6);

    // Soft-start ramp 0->7 then down to 2, from a fresh enable.
    cyc(1'b0, 3'd7);
    ramp_q.delete();
    for (int i = 0; i < 8 * 32 + 2; i++) begin
      cyc(1'b1, 3'd7);
      if (if1.period_start) ramp_q.push_back(if1.duty_applied);
    end
    chk("ramp_up_count", 32'(ramp_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < ramp_q.size(); i++)
      chk($sformatf("ramp_up_%0d", i), 32'(ramp_q[i]), 32'(ramp_up[i]));
    ramp_q.delete();
    for (int i = 0; i < 6 * 32; i++) begin
      cyc(1'b1, 3'd2);
      if (if1.period_start) ramp_q.push_back(if1.duty_applied);
    end
    chk("ramp_dn_count", 32'(ramp_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < ramp_q.size(); i++)
      chk($sformatf("ramp_dn_%0d", i), 32'(ramp_q[i]), 32'(ramp_dn[i]));

    // Mid-period dc toggles are ignored until the boundary.
    for (int i = 0; i < 40; i++) cyc(1'b1, 3'd5);
    for (int i = 0; i < 64; i++) cyc(1'b1, (i % 8 < 4) ? 3'd1 : 3'd5);

    // Drop en while dut0 is high at trigger 2.
    guard = 0;
    while (!(if0.trigger == 3'd2 && if0.pwm) && guard < 100) begin
      cyc(1'b1, 3'd5);
      guard++;
    end
    chk("en_drop_wait_bound", 32'(guard < 100), 32'd1);
    cyc(1'b0, 3'd5);
    chk("en_drop_trigger", 32'(if0.trigger), 32'd0);
    chk("en_drop_duty", 32'(if0.duty_applied), 32'd0);
    chk("en_drop_pwm", 32'(if0.pwm), 32'd0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 3'd7);

    // Reset mid-period, then the fresh-start sequence again.
    for (int i = 0; i < 13; i++) cyc(1'b1, 3'd6);
    reset_pulse();
    chk("rst_duty_dut1", 32'(if1.duty_applied), 32'd0);
    for (int i = 0; i < 80; i++) cyc(1'b1, 3'd6);

    // Randomized run with occasional en drops, dc changes and reset pulses.
    rd = 3'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) rd = 3'($urandom_range(7));
      re = ($urandom_range(63) != 0);
      cyc(re, rd);
      if ($urandom_range(299) == 0) reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
